// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding for the serial-side FSMs
package serial_pkg;

  typedef logic [2:0] serial_state_t;

  localparam serial_state_t ST_IDLE    = 3'd0;
  localparam serial_state_t ST_LOAD    = 3'd1;
  localparam serial_state_t ST_WAIT_HI = 3'd2;
  localparam serial_state_t ST_WAIT_LO = 3'd3;
  localparam serial_state_t ST_GUARD   = 3'd4;
  localparam serial_state_t ST_RELEASE = 3'd5;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, first set request at or after rr_ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  sel,
  output logic          valid
);

  int idx;

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(rr_ptr) + off) % N;
      if (!valid && req[idx]) begin
        sel[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin arbiter sharing the quick_rs232 transmitter
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int GUARD_CYCLES = 10,
  parameter int COPY_TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_transaction,
  output logic [7:0]           tx_data,
  output logic                 tx_data_ready,
  input  logic                 tx_data_copied,
  output logic                 timeout_err
);

  localparam int          IW         = $clog2(NUM_REQ);
  localparam logic [31:0] TMO_LIM    = 32'(COPY_TIMEOUT);
  // GUARD_CYCLES must be at least 1; the guard state lasts exactly that many clocks
  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);
  localparam logic [7:0]  BURST_LIM  = 8'(MAX_BURST);

  serial_state_t state, next_state;
  logic [IW-1:0]      owner, rr_ptr, pick_idx;
  logic [NUM_REQ-1:0] pick_sel;
  logic               pick_valid;
  logic [7:0]         burst_cnt;
  logic [31:0]        cnt;
  logic               tmo_hit, guard_done, burst_more;
  logic               do_grant, do_load, do_ack, do_abort, do_drop, do_release;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .sel    (pick_sel),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_sel[i]) pick_idx = IW'(i);
  end

  assign tmo_hit    = (cnt == TMO_LIM);
  assign guard_done = (cnt == GUARD_LAST);
  assign burst_more = req[owner] && (burst_cnt < BURST_LIM);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (pick_valid) next_state = ST_LOAD;
      ST_LOAD:    next_state = ST_WAIT_HI;
      ST_WAIT_HI: if (tx_data_copied) next_state = ST_WAIT_LO;
                  else if (tmo_hit)   next_state = ST_RELEASE;
      ST_WAIT_LO: if (!tx_data_copied) next_state = ST_GUARD;
                  else if (tmo_hit)    next_state = ST_RELEASE;
      ST_GUARD:   if (guard_done) next_state = burst_more ? ST_LOAD : ST_RELEASE;
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    do_grant   = (state == ST_IDLE) && pick_valid;
    do_load    = (state == ST_LOAD);
    do_ack     = (state == ST_WAIT_HI) && tx_data_copied;
    do_abort   = tmo_hit && (((state == ST_WAIT_HI) && !tx_data_copied) ||
                             ((state == ST_WAIT_LO) &&  tx_data_copied));
    do_drop    = (state == ST_WAIT_LO) && !tx_data_copied;
    do_release = (state == ST_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack            <= '0;
      grant          <= '0;
      owner          <= '0;
      rr_ptr         <= '0;
      burst_cnt      <= '0;
      cnt            <= '0;
      tx_transaction <= 1'b0;
      tx_data        <= '0;
      tx_data_ready  <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      ack <= '0;
      // one counter serves both the copy timeout and the guard gap
      if (next_state != state)
        cnt <= '0;
      else if (state inside {ST_WAIT_HI, ST_WAIT_LO, ST_GUARD})
        cnt <= cnt + 32'd1;
      if (do_grant) begin
        grant          <= pick_sel;
        owner          <= pick_idx;
        tx_transaction <= 1'b1;
        burst_cnt      <= '0;
      end
      if (do_load) begin
        tx_data       <= req_data[{owner, 3'b000} +: 8];
        tx_data_ready <= 1'b1;
      end
      if (do_ack) begin
        ack <= grant;
        if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
      end
      if (do_abort) begin
        timeout_err   <= 1'b1;
        tx_data_ready <= 1'b0;
      end
      if (do_drop) tx_data_ready <= 1'b0;
      if (do_release) begin
        tx_transaction <= 1'b0;
        grant          <= '0;
        rr_ptr         <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - scoreboard bench with a behavioural quick_rs232 tx model
module tb_serial_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int GC = 3;
  localparam int CT = 100;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack, grant;
  logic           tx_transaction;
  logic [7:0]     tx_data;
  logic           tx_data_ready;
  logic           tx_data_copied;
  logic           timeout_err;

  always #5 clk = ~clk;

  serial_tx_arbiter #(
    .NUM_REQ(N), .MAX_BURST(MB), .GUARD_CYCLES(GC), .COPY_TIMEOUT(CT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .ack            (ack),
    .grant          (grant),
    .tx_transaction (tx_transaction),
    .tx_data        (tx_data),
    .tx_data_ready  (tx_data_ready),
    .tx_data_copied (tx_data_copied),
    .timeout_err    (timeout_err)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {int who; logic [7:0] d;} item_t;

  int    tests = 0, fails = 0, viol = 0, ack_total = 0;
  item_t exp_q[$];
  bq_t   rq[N];
  bq_t   stage[N];
  int    model_p = 0;
  bit    stall = 1'b0;
  int    u_phase = 0, u_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // quick_rs232 behaviour: copied rises 3 clks after ready, falls 2 clks later
  task automatic uart_step();
    if (rst) begin
      tx_data_copied = 1'b0;
      u_phase = 0;
    end else begin
      case (u_phase)
        0: if (tx_data_ready && !stall) begin u_phase = 1; u_cnt = 1; end
        1: begin
          u_cnt++;
          if (u_cnt == 3) begin tx_data_copied = 1'b1; u_phase = 2; u_cnt = 0; end
        end
        2: begin
          u_cnt++;
          if (u_cnt == 2) begin tx_data_copied = 1'b0; u_phase = 3; end
        end
        default: if (!tx_data_ready) u_phase = 0;
      endcase
    end
  endtask

  // requesters: on ack, present the next queued byte or drop req
  task automatic drv_step();
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        ack_total++;
        if (rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) req_data[8*i +: 8] = rq[i][0];
        else req[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    uart_step();
    drv_step();
  endtask

  // reference: grant to first non-empty requester from the pointer, serve up to MB bytes
  task automatic model_batch();
    bq_t m[N];
    for (int i = 0; i < N; i++) m[i] = rq[i];
    while (1) begin
      int o;
      o = -1;
      for (int off = 0; off < N; off++) begin
        int c;
        c = (model_p + off) % N;
        if (o < 0 && m[c].size() > 0) o = c;
      end
      if (o < 0) break;
      for (int k = 0; k < MB && m[o].size() > 0; k++) begin
        item_t it;
        it.who = o;
        it.d   = m[o].pop_front();
        exp_q.push_back(it);
      end
      model_p = (o + 1) % N;
    end
  endtask

  task automatic start_batch();
    for (int i = 0; i < N; i++) begin
      rq[i] = stage[i];
      stage[i].delete();
      if (rq[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[8*i +: 8] = rq[i][0];
      end
    end
    model_batch();
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && req == '0 && !tx_transaction) && k < 3000) begin
      tick();
      k++;
    end
    check(name, 32'(k < 3000), 32'd1);
  endtask

  task automatic do_reset(input string name);
    req = '0;
    for (int i = 0; i < N; i++) rq[i].delete();
    rst = 1'b1;
    tick();
    check(name, {13'd0, ack, grant, tx_transaction, tx_data, tx_data_ready, timeout_err}, 32'd0);
    rst = 1'b0;
    model_p = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if ((grant & (grant - 4'd1)) != 0) viol++;
    if ((ack & ~grant) != 0) viol++;
    if (ack != 0) begin
      if (exp_q.size() == 0) check("unexpected_ack", 32'(ack), 32'd0);
      else begin
        item_t it;
        it = exp_q.pop_front();
        check("ack_who", 32'(ack), 32'd1 << it.who);
        check("ack_data", 32'(tx_data), 32'(it.d));
        check("ack_in_transaction", 32'(tx_transaction), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, g, c, acks0;
    rst = 1'b1; req = '0; req_data = '0; tx_data_copied = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {13'd0, ack, grant, tx_transaction, tx_data, tx_data_ready, timeout_err}, 32'd0);
    rst = 1'b0;
    tick();

    stage[2].push_back(8'h41);
    start_batch();
    lat = 0;
    while (!tx_data_ready && lat < 10) begin tick(); lat++; end
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_grant", 32'(grant), 32'b0100);
    check("t1_tx_data", 32'(tx_data), 32'h41);
    c = 0;
    while (tx_data_ready && c < 100) begin tick(); c++; end
    g = 0;
    while (tx_transaction && g < 100) begin tick(); g++; end
    check("t1_guard_gap", 32'(g), 32'(GC + 1));
    wait_done("t1_done");

    do_reset("reset_between");
    for (int i = 0; i < N; i++) stage[i].push_back(8'(8'h10 + i));
    start_batch();
    wait_done("t2_contention");

    for (int j = 0; j < 5; j++) stage[0].push_back(8'(8'h30 + j));
    stage[1].push_back(8'h50);
    start_batch();
    wait_done("t3_burst_cap");

    stage[3].push_back(8'hA3);
    stage[0].push_back(8'hA0);
    start_batch();
    wait_done("t6_wrap");

    for (int b = 0; b < 6; b++) begin
      int tot;
      tot = 0;
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) stage[i].push_back(8'($urandom));
        tot += n;
      end
      if (tot == 0) stage[$urandom_range(0, N-1)].push_back(8'($urandom));
      start_batch();
      wait_done("rand_batch");
    end

    stall = 1'b1;
    acks0 = ack_total;
    rq[2].push_back(8'hEE);
    req[2] = 1'b1;
    req_data[23:16] = 8'hEE;
    c = 0;
    while (!timeout_err && c < 300) begin tick(); c++; end
    check("t4_timeout_window", 32'(c >= 101 && c <= 104), 32'd1);
    req[2] = 1'b0;
    rq[2].delete();
    model_p = 3;
    repeat (3) tick();
    check("t4_grant", 32'(grant), 32'd0);
    check("t4_transaction", 32'(tx_transaction), 32'd0);
    check("t4_ready", 32'(tx_data_ready), 32'd0);
    check("t4_no_ack", 32'(ack_total - acks0), 32'd0);
    stall = 1'b0;
    stage[0].push_back(8'h77);
    start_batch();
    wait_done("t4_recover");
    check("t4_sticky", 32'(timeout_err), 32'd1);

    stage[1].push_back(8'h55);
    start_batch();
    c = 0;
    while (ack[1] == 1'b0 && c < 100) begin tick(); c++; end
    check("t5_reached_ack", 32'(c < 100), 32'd1);
    tick();
    do_reset("t5_reset_wait_lo");
    stage[1].push_back(8'h66);
    stage[2].push_back(8'h67);
    start_batch();
    wait_done("t5_after_reset");

    repeat (5) tick();
    check("grant_onehot_ack_subset", 32'(viol), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
